// File: rtl/gpu_reg_initiator.sv
// rtl/gpu_reg_initiator.sv - register-ring initiator issuing single write/read/poll commands to the GPU responder
module gpu_reg_initiator #(
    parameter int                           UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = 2'd1,
    parameter logic [7:0]                   GPU_ADDR_PREFIX   = 8'h7F,
    parameter int                           TIMEOUT           = 255,
    parameter int                           POLL_MAX          = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [7:0]                   cmd_off,
    input  logic [31:0]                  cmd_data,
    input  logic [31:0]                  cmd_mask,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_data,
    output logic [1:0]                   rsp_status,
    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [22:0]                  reg_addr_in,
    input  logic [31:0]                  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [22:0]                  reg_addr_out,
    output logic [31:0]                  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);
    localparam logic [1:0]  OP_WR      = 2'd0;
    localparam logic [1:0]  OP_POLL    = 2'd2;
    localparam logic [1:0]  OP_NOP     = 2'd3;
    localparam logic [1:0]  ST_OK      = 2'd0;
    localparam logic [1:0]  ST_NACK    = 2'd1;
    localparam logic [1:0]  ST_TMO     = 2'd2;
    localparam logic [1:0]  ST_EXH     = 2'd3;
    localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [10:0] POLL_MAX_C = 11'(POLL_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                         state_q;
    logic [1:0]                     op_q;
    logic [7:0]                     off_q;
    logic [31:0]                    wdata_q;
    logic [31:0]                    mask_q;
    logic [31:0]                    rdata_q;
    logic [1:0]                     status_q;
    logic [7:0]                     tmo_q;
    logic [10:0]                    poll_q;
    logic                           req_out_q;
    logic                           ack_out_q;
    logic                           rd_wr_L_out_q;
    logic [22:0]                    addr_out_q;
    logic [31:0]                    data_out_q;
    logic [UDP_REG_SRC_WIDTH-1:0]   src_out_q;
    logic                           rsp_valid_q;
    logic [31:0]                    rsp_data_q;
    logic [1:0]                     rsp_status_q;

    logic                           own_in;
    logic                           poll_hit;
    logic [7:0]                     tmo_d;
    logic [10:0]                    poll_d;

    assign own_in   = reg_req_in && (reg_src_in == SRC_ID);
    assign poll_hit = ((reg_data_in & mask_q) == (wdata_q & mask_q));
    assign tmo_d    = tmo_q + 8'd1;
    assign poll_d   = poll_q + 11'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            op_q          <= 2'd0;
            off_q         <= 8'd0;
            wdata_q       <= 32'd0;
            mask_q        <= 32'd0;
            rdata_q       <= 32'd0;
            status_q      <= ST_OK;
            tmo_q         <= 8'd0;
            poll_q        <= 11'd0;
            req_out_q     <= 1'b0;
            ack_out_q     <= 1'b0;
            rd_wr_L_out_q <= 1'b0;
            addr_out_q    <= 23'd0;
            data_out_q    <= 32'd0;
            src_out_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_status_q  <= ST_OK;
        end else begin
            // Own transactions terminate here in every state; everything else passes through.
            if (own_in) begin
                req_out_q     <= 1'b0;
                ack_out_q     <= 1'b0;
                rd_wr_L_out_q <= 1'b0;
                addr_out_q    <= 23'd0;
                data_out_q    <= 32'd0;
                src_out_q     <= '0;
            end else begin
                req_out_q     <= reg_req_in;
                ack_out_q     <= reg_ack_in;
                rd_wr_L_out_q <= reg_rd_wr_L_in;
                addr_out_q    <= reg_addr_in;
                data_out_q    <= reg_data_in;
                src_out_q     <= reg_src_in;
            end
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_status_q <= ST_OK;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        off_q    <= cmd_off;
                        wdata_q  <= cmd_data;
                        mask_q   <= cmd_mask;
                        rdata_q  <= 32'd0;
                        status_q <= ST_OK;
                        poll_q   <= 11'd0;
                        state_q  <= (cmd_op == OP_NOP) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!reg_req_in) begin
                        req_out_q     <= 1'b1;
                        ack_out_q     <= 1'b0;
                        rd_wr_L_out_q <= (op_q != OP_WR);
                        addr_out_q    <= {GPU_ADDR_PREFIX, 7'b0, off_q};
                        data_out_q    <= (op_q == OP_WR) ? wdata_q : 32'd0;
                        src_out_q     <= SRC_ID;
                        tmo_q         <= 8'd0;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_q <= tmo_d;
                    // A return wins over a timeout expiring in the same cycle.
                    if (own_in) begin
                        if (!reg_ack_in) begin
                            status_q <= ST_NACK;
                            state_q  <= S_DONE;
                        end else begin
                            if (op_q != OP_WR) rdata_q <= reg_data_in;
                            if (op_q == OP_POLL && !poll_hit) begin
                                poll_q <= poll_d;
                                if (poll_d < POLL_MAX_C) begin
                                    state_q <= S_ISSUE;
                                end else begin
                                    status_q <= ST_EXH;
                                    state_q  <= S_DONE;
                                end
                            end else begin
                                state_q <= S_DONE;
                            end
                        end
                    end else if (tmo_d == TIMEOUT_C) begin
                        status_q <= ST_TMO;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= rdata_q;
                    rsp_status_q <= status_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready       = (state_q == S_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_status      = rsp_status_q;
    assign reg_req_out     = req_out_q;
    assign reg_ack_out     = ack_out_q;
    assign reg_rd_wr_L_out = rd_wr_L_out_q;
    assign reg_addr_out    = addr_out_q;
    assign reg_data_out    = data_out_q;
    assign reg_src_out     = src_out_q;
endmodule

// File: tb/tb_gpu_reg_initiator.sv
// tb/tb_gpu_reg_initiator.sv - scoreboard bench for gpu_reg_initiator over a modelled register ring
module tb_gpu_reg_initiator;
    localparam logic [1:0] SRC_ID = 2'd1;
    localparam int M_LOOP  = 0;
    localparam int M_GPU   = 1;
    localparam int M_STALL = 2;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_off;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [22:0] reg_addr_in;
    logic [31:0] reg_data_in;
    logic [1:0]  reg_src_in;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;

    gpu_reg_initiator #(
        .UDP_REG_SRC_WIDTH(2), .SRC_ID(SRC_ID), .GPU_ADDR_PREFIX(8'h7F),
        .TIMEOUT(255), .POLL_MAX(1024)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_off(cmd_off),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
        int          at;
        string       name;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // ring model state
    int          mode = M_GPU;
    int          hold_len = 0;
    logic        req_allowed = 1'b1;
    logic        exp_rdwr;
    logic [22:0] exp_addr;
    logic [31:0] exp_wdata;
    int          fg_left = 0;
    int          fg_cnt = 0;
    logic        fwd_pending = 1'b0;
    logic [59:0] fwd_exp;
    logic        ret_pending = 1'b0;
    logic        held = 1'b0;
    int          held_cnt = 0;
    logic        h_rdwr;
    logic [22:0] h_addr;
    logic [31:0] h_data;
    logic [31:0] gregs [256];
    logic        started = 1'b0;
    int          kreads = 0;
    int          klen = 3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT completes.
    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {32'd0, rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_data"}, {32'd0, rsp_data}, {32'd0, e.data});
                    check({e.name, "_status"}, {62'd0, rsp_status}, {62'd0, e.status});
                    if (e.at >= 0) check({e.name, "_cycle"}, cyc, e.at);
                end
            end
        end
    end

    // Ring model: loopback / GPU responder / stall, plus foreign traffic injection.
    initial begin : ring
        logic        have_ret;
        logic        r_ack, r_rdwr;
        logic [22:0] r_addr;
        logic [31:0] r_data;
        logic [7:0]  r_off;
        forever begin
            @(negedge clk);
            if (fwd_pending) begin
                check("fwd", {4'd0, reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                              reg_data_out, reg_src_out}, {4'd0, fwd_exp});
                fwd_pending = 1'b0;
            end
            if (ret_pending) begin
                check("own_consumed", {63'd0, reg_req_out}, 64'd0);
                ret_pending = 1'b0;
            end
            if (held && held_cnt > 0) held_cnt = held_cnt - 1;
            have_ret = 1'b0;
            r_ack = 1'b0; r_rdwr = 1'b0; r_addr = '0; r_data = '0;
            if (reg_req_out === 1'b1 && reg_src_out == SRC_ID) begin
                check("req_allowed", {63'd0, req_allowed}, 64'd1);
                check("req_fields", {7'd0, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out},
                      {7'd0, 1'b0, exp_rdwr, exp_addr, exp_wdata});
                r_rdwr = reg_rd_wr_L_out;
                r_addr = reg_addr_out;
                r_data = reg_data_out;
                r_off  = reg_addr_out[7:0];
                if (mode == M_LOOP) begin
                    have_ret = 1'b1;
                end else if (mode == M_GPU) begin
                    r_ack = 1'b1;
                    if (!r_rdwr) begin
                        if (r_off == 8'd0) begin
                            if (r_data[0]) begin started = 1'b1; kreads = 0; end
                        end else begin
                            gregs[r_off] = r_data;
                        end
                    end else if (r_off == 8'd0) begin
                        kreads = kreads + 1;
                        r_data = !started ? 32'd0 : (kreads > klen) ? 32'd2 : 32'd1;
                    end else begin
                        r_data = gregs[r_off];
                    end
                    have_ret = 1'b1;
                end else begin
                    held = 1'b1; held_cnt = hold_len;
                    h_rdwr = r_rdwr; h_addr = r_addr; h_data = r_data;
                end
            end
            if (!have_ret && held && held_cnt == 0) begin
                have_ret = 1'b1; held = 1'b0;
                r_ack = 1'b1; r_rdwr = h_rdwr; r_addr = h_addr; r_data = h_data;
            end
            if (have_ret) begin
                reg_req_in = 1'b1; reg_ack_in = r_ack; reg_rd_wr_L_in = r_rdwr;
                reg_addr_in = r_addr; reg_data_in = r_data; reg_src_in = SRC_ID;
                ret_pending = 1'b1;
            end else if (fg_left > 0) begin
                reg_req_in = 1'b1; reg_ack_in = fg_cnt[0]; reg_rd_wr_L_in = fg_cnt[1];
                reg_addr_in = 23'h12_3400 + 23'(fg_cnt);
                reg_data_in = 32'hA5A5_0000 ^ (32'h0101_0101 * 32'(fg_cnt + 1));
                reg_src_in = 2'd0;
                fwd_exp = {reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in};
                fwd_pending = 1'b1;
                fg_left = fg_left - 1;
                fg_cnt = fg_cnt + 1;
            end else begin
                reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
                reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
            end
        end
    end

    task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] off,
                          input logic [31:0] data, input logic [31:0] mask,
                          input logic push, input logic [31:0] edata, input logic [1:0] est,
                          input int lat, input int fg);
        rsp_t e;
        @(negedge clk);
        check({name, "_ready"}, {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_off = off; cmd_data = data; cmd_mask = mask;
        req_allowed = (op != 2'd3);
        exp_rdwr  = (op != 2'd0);
        exp_addr  = {8'h7F, 7'b0, off};
        exp_wdata = (op == 2'd0) ? data : 32'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (push) begin
            e.data = edata; e.status = est; e.name = name;
            e.at = (lat < 0) ? -1 : cyc + lat;
            exp_q.push_back(e);
        end
        fg_left = fg;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_held_clear(input int budget);
        int n;
        n = 0;
        while ((held || ret_pending) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        if (held) check("held_release_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, {63'd0, cmd_ready}, 64'd1);
        check({name, "_rsp"}, {29'd0, rsp_valid, rsp_data, rsp_status}, 64'd0);
        check({name, "_ring"}, {4'd0, reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                                reg_data_out, reg_src_out}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_off = 8'd0;
        cmd_data = 32'd0; cmd_mask = 32'd0;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // write then read through the GPU responder; ring round trip N = 1
        mode = M_GPU;
        do_cmd("write_01", 2'd0, 8'h01, 32'h0000_0040, 32'd0, 1'b1, 32'd0, 2'd0, 3, 0);
        wait_drain(20);
        do_cmd("read_01", 2'd1, 8'h01, 32'd0, 32'd0, 1'b1, 32'h0000_0040, 2'd0, 3, 0);
        wait_drain(20);

        // reserved op completes next cycle without touching the ring
        do_cmd("nop", 2'd3, 8'h22, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'd0, 2'd0, 1, 0);
        wait_drain(20);

        // loopback ring: own request comes back unacknowledged
        mode = M_LOOP;
        do_cmd("nack_05", 2'd1, 8'h05, 32'd0, 32'd0, 1'b1, 32'd0, 2'd1, 3, 0);
        wait_drain(20);

        // return stalled past the timeout, then arrives late and is swallowed
        mode = M_STALL; hold_len = 300;
        do_cmd("timeout", 2'd1, 8'h10, 32'd0, 32'd0, 1'b1, 32'd0, 2'd2, 257, 0);
        wait_drain(400);
        wait_held_clear(400);

        // poll for done on a short kernel
        mode = M_GPU; klen = 3;
        do_cmd("start_a", 2'd0, 8'h00, 32'd1, 32'd0, 1'b1, 32'd0, 2'd0, 3, 0);
        wait_drain(20);
        do_cmd("poll_ok", 2'd2, 8'h00, 32'd2, 32'd2, 1'b1, 32'd2, 2'd0, 9, 0);
        wait_drain(50);

        // never-finishing kernel exhausts the poll budget
        klen = 1000000;
        do_cmd("start_b", 2'd0, 8'h00, 32'd1, 32'd0, 1'b1, 32'd0, 2'd0, 3, 0);
        wait_drain(20);
        do_cmd("poll_exh", 2'd2, 8'h00, 32'd2, 32'd2, 1'b1, 32'd1, 2'd3, 2049, 0);
        wait_drain(2200);

        // ten cycles of foreign traffic while in ISSUE delay the request by ten slots
        do_cmd("read_fg", 2'd1, 8'h01, 32'd0, 32'd0, 1'b1, 32'h0000_0040, 2'd0, 13, 10);
        wait_drain(40);

        // reset while waiting; the old return is dropped afterwards
        mode = M_STALL; hold_len = 20;
        do_cmd("rst_wait", 2'd1, 8'h01, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, -1, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_held_clear(60);
        mode = M_GPU;
        do_cmd("read_after_rst", 2'd1, 8'h01, 32'd0, 32'd0, 1'b1, 32'h0000_0040, 2'd0, 3, 0);
        wait_drain(20);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
